// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, polarity helper and slot FSM states for seg7_scan_ctrl
package seg7_pkg;
  typedef enum logic {DEAD, ON} state_e;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [7:0] apply_pol(input logic [7:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction
endpackage

// File: rtl/hex7_decode.sv
// hex7_decode: nibble to active-high 7-segment glyph, bit 0 = a
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  assign glyph = GLYPH[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: double-buffered multiplexed 7-segment scanner; define SEG7_SCAN_BLINK_EN for per-digit blinking
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLINK_FRAMES   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digit_val,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  output logic [6:0]            segment,
  output logic [N_DIGITS-1:0]   digit,
  output logic                  frame_start,
  output logic                  pending
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW != 0 ? '1 : '0;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  state_e state_q, state_d;
  logic [6:0] seg_q, seg_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;
  logic fs_q, fs_d, pend_q, pend_d;
  logic [4*N_DIGITS-1:0] pv_q, pv_d, av_q, av_d;
  logic [N_DIGITS-1:0] pb_q, pb_d, ab_q, ab_d, pk_q, pk_d, ak_q, ak_d;
  logic wrap, last, lit, blink_off;
  logic [6:0] glyph;
  logic [7:0] seg8, dig8;
  logic unused_pol;
  hex7_decode u_dec (.nib(av_q[idx_q*4 +: 4]), .glyph(glyph));
  always_comb begin
    wrap = cnt_q == CW'(PRESCALE - 1);
    last = wrap && idx_q == IW'(N_DIGITS - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? (last ? '0 : idx_q + 1'b1) : idx_q;
    state_d = cnt_d < CW'(DEAD_CYCLES) ? DEAD : ON;
    // last-cycle load bypasses the pending buffer straight into the active one
    pend_d = last ? 1'b0 : (load | pend_q);
    pv_d = load ? digit_val : pv_q;
    pb_d = load ? blank_mask : pb_q;
    pk_d = load ? blink_mask : pk_q;
    av_d = last ? (load ? digit_val : pv_q) : av_q;
    ab_d = last ? (load ? blank_mask : pb_q) : ab_q;
    ak_d = last ? (load ? blink_mask : pk_q) : ak_q;
    lit = state_q == ON && !ab_q[idx_q] && !blink_off;
    seg8 = apply_pol({1'b0, lit ? glyph : SEG_OFF}, SEG_ACTIVE_LOW != 0);
    dig8 = apply_pol(state_q == ON ? 8'b1 << idx_q : 8'h00, DIG_ACTIVE_LOW != 0);
    seg_d = seg8[6:0];
    dig_d = dig8[N_DIGITS-1:0];
    fs_d = cnt_q == '0 && idx_q == '0;
    unused_pol = ^{seg8, dig8};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      state_q <= DEAD;
      seg_q <= SEG_IDLE;
      dig_q <= DIG_IDLE;
      fs_q <= 1'b0;
      pend_q <= 1'b0;
      pv_q <= '0;
      av_q <= '0;
      pb_q <= '1;
      ab_q <= '1;
      pk_q <= '0;
      ak_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      state_q <= state_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
      fs_q <= fs_d;
      pend_q <= pend_d;
      pv_q <= pv_d;
      av_q <= av_d;
      pb_q <= pb_d;
      ab_q <= ab_d;
      pk_q <= pk_d;
      ak_q <= ak_d;
    end
  end
`ifdef SEG7_SCAN_BLINK_EN
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic phase_q, phase_d, tog;
  logic [FW-1:0] fcnt_q, fcnt_d;
  always_comb begin
    tog = last && fcnt_q == FW'(BLINK_FRAMES - 1);
    fcnt_d = last ? (tog ? '0 : fcnt_q + 1'b1) : fcnt_q;
    phase_d = tog ? ~phase_q : phase_q;
    blink_off = ~phase_q & ak_q[idx_q];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      phase_q <= phase_d;
      fcnt_q <= fcnt_d;
    end
  end
`else
  logic unused_blink;
  assign blink_off = 1'b0;
  assign unused_blink = ^{ak_q, BLINK_FRAMES[0]};
`endif
  assign segment = seg_q;
  assign digit = dig_q;
  assign frame_start = fs_q;
  assign pending = pend_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: per-cycle scoreboard against a frame-level reference model
module tb_seg7_scan_ctrl;
  localparam int N = 4, P = 8, D = 2, NF = 16, FR = N * P;
  localparam logic [6:0] GL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       fs;
    logic       pend;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [15:0] digit_val = '0;
  logic [3:0] blank_mask = '0, blink_mask = '0;
  logic [6:0] segment;
  logic [3:0] digit;
  logic frame_start, pending;
  exp_t sb [$];
  int n_vec = 0, n_err = 0, pos = 0;
  logic mpend = 1'b0;
  logic [15:0] fv [NF];
  logic [3:0] fb [NF], fk [NF];
  seg7_scan_ctrl #(
    .N_DIGITS(N), .PRESCALE(P), .DEAD_CYCLES(D),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digit_val(digit_val),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .segment(segment),
    .digit(digit), .frame_start(frame_start), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic l, input logic [15:0] v, input logic [3:0] b, input logic [3:0] bk);
    exp_t e, o;
    int s, d, f;
    logic off;
    @(negedge clk);
    rst_n = ~r;
    load = l;
    digit_val = v;
    blank_mask = b;
    blink_mask = bk;
    e = '0;
    if (r) begin
      for (int i = 0; i < NF; i++) begin
        fv[i] = '0;
        fb[i] = 4'hF;
        fk[i] = '0;
      end
      mpend = 1'b0;
      pos = 0;
      e.seg = 7'h7F;
      e.dig = 4'hF;
    end else begin
      if (l)
        for (int i = pos / FR + 1; i < NF; i++) begin
          fv[i] = v;
          fb[i] = b;
          fk[i] = bk;
        end
      mpend = (pos % FR == FR - 1) ? 1'b0 : (l | mpend);
      s = pos % P;
      d = (pos / P) % N;
      f = pos / FR;
      if (f >= NF) f = NF - 1;
      off = fb[f][d];
`ifdef SEG7_SCAN_BLINK_EN
      off = off | (fk[f][d] && ((f / 2) % 2 == 1));
`endif
      e.fs = (pos % FR) == 0;
      e.pend = mpend;
      if (s < D) begin
        e.seg = 7'h7F;
        e.dig = 4'hF;
      end else begin
        e.dig = ~(4'b0001 << d);
        e.seg = off ? 7'h7F : ~GL[fv[f][d*4 +: 4]];
      end
      pos++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("segment", 16'(segment), 16'(o.seg));
    chk("digit", 16'(digit), 16'(o.dig));
    chk("frame_start", 16'(frame_start), 16'(o.fs));
    chk("pending", 16'(pending), 16'(o.pend));
  endtask
  initial begin
    repeat (3) cyc(1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 300; k++)
      case (k)
        40:      cyc(1'b0, 1'b1, 16'h4321, 4'h0, 4'h1);
        100:     cyc(1'b0, 1'b1, 16'h1111, 4'h0, 4'h1);
        110:     cyc(1'b0, 1'b1, 16'hABCD, 4'h0, 4'h1);
        191:     cyc(1'b0, 1'b1, 16'h5678, 4'h0, 4'h1);
        200:     cyc(1'b0, 1'b1, 16'h9EF0, 4'h4, 4'h1);
        default: cyc(1'b0, 1'b0, '0, '0, '0);
      endcase
    repeat (2) cyc(1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 120; k++)
      if (k == 13) cyc(1'b0, 1'b1, 16'h0FA7, 4'h2, 4'h0);
      else cyc(1'b0, 1'b0, '0, '0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
